fetch_queue: RTL and testbench

- Parametrised successor to the single-register fetch stage: PC generation, a decoupled instruction-memory request/response interface with variable latency, and a DEPTH-entry prefetch buffer feeding decode.
- Sits between the PC/instruction memory and the decode pipeline register.
- Decode back-pressure replaces StallF/StallD.
- An execute-stage redirect (taken branch or jump) replaces FlushD and discards all stale fetches.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/fetch_queue.sv | 126 ++++++++++++
 tb/tb_fetch_queue.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch queue and its prefetch buffer.
package fetch_pkg;
  localparam int INSTR_W    = 32;
  localparam int PC_INC     = 4;
  localparam int FETCH_XLEN = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [INSTR_W-1:0]    instr;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with combinational head read, synchronous clear
// and active-low asynchronous reset of the control state.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is data only; validity is tracked entirely by the pointers above.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: PC generation, credit-limited imem requests and a prefetch buffer
// feeding decode. Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  localparam int             OCC_W           = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [XLEN-1:0]    dec_pc,
  output logic [XLEN-1:0]    dec_pc_plus4,
  output logic [INSTR_W-1:0] dec_instr,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic               fetch_misaligned,
`endif
  output logic [OCC_W-1:0]   occupancy
);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int ENT_W = XLEN + INSTR_W;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [OUT_W-1:0] out_q, out_d, stale_q, stale_d;
  logic [XLEN-1:0]  redirect_aligned;
  logic [ENT_W-1:0] fifo_din, fifo_dout;
  logic [OCC_W-1:0] fifo_count;
  logic             fifo_empty, fifo_push, fifo_pop;
  logic             credit_ok, trap_block, req_fire, rsp_live, rsp_keep;

  assign redirect_aligned = redirect_pc & ~XLEN'(PC_INC - 1);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  assign trap_block       = mis_q;
  assign fetch_misaligned = mis_q;

  always_comb begin
    mis_d = mis_q;
    if (redirect_valid) mis_d = (redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end
`else
  assign trap_block = 1'b0;
`endif

  // Buffer entries plus in-flight requests never exceed DEPTH, so pushes cannot overflow.
  assign credit_ok = (int'(fifo_count) + int'(out_q) < DEPTH) &&
                     (int'(out_q) < MAX_OUTSTANDING);

  assign imem_req_valid = reset && !redirect_valid && !trap_block && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a leftover from before reset: absorb it.
  assign rsp_live  = imem_rsp_valid && (out_q != '0);
  assign rsp_keep  = rsp_live && (stale_q == '0) && !redirect_valid;
  assign fifo_push = rsp_keep;
  assign fifo_pop  = dec_ready && !redirect_valid;
  assign fifo_din  = {rsp_pc_q, imem_rsp_data};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q + OUT_W'(req_fire) - OUT_W'(rsp_live);
    stale_d    = stale_q;
    if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
    if (rsp_keep) rsp_pc_d   = rsp_pc_q + XLEN'(PC_INC);
    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      stale_d    = out_q - OUT_W'(rsp_live);
    end else if (rsp_live && stale_q != '0) begin
      stale_d = stale_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      stale_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      stale_q    <= stale_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (redirect_valid),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign dec_valid             = !fifo_empty;
  assign {dec_pc, dec_instr}   = fifo_dout;
  assign dec_pc_plus4          = dec_pc + XLEN'(PC_INC);
  assign occupancy             = fifo_count;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model of requests in flight and
// buffered entries, with a variable-latency in-order instruction memory.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_pc, dec_pc_plus4, dec_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  occupancy;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  fetch_queue #(
    .XLEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
    .dec_pc_plus4(dec_pc_plus4), .dec_instr(dec_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .fetch_misaligned(fetch_misaligned),
`endif
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } req_t;

  req_t        infl[$];
  logic [31:0] bufq[$];
  logic [31:0] popped[$];
  logic [31:0] reqs[$];
  logic [31:0] exp_fetch;
  bit          mis_m;
  int          cyc, lat_min, lat_max, last_due, rdy_pct;
  int          n_cmp, n_fail;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic model_reset();
    infl.delete();
    bufq.delete();
    popped.delete();
    reqs.delete();
    exp_fetch = RESET_PC;
    mis_m     = 1'b0;
    last_due  = 0;
  endtask

  task automatic drive_imem();
    imem_req_ready = (int'($urandom_range(99, 0)) < rdy_pct);
    if (infl.size() != 0 && infl[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memfn(infl[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  // One clock: compare DUT against the model before the edge, then advance the model.
  task automatic tick();
    bit   exp_req;
    req_t e;
    int   d;
    @(negedge clk);
    exp_req = !redirect_valid && !mis_m &&
              (bufq.size() + infl.size() < DEPTH) && (infl.size() < MAX_OUT);
    n_cmp++;
    if (imem_req_valid !== exp_req) begin
      n_fail++;
      $display("FAIL req_valid cyc=%0d: got %b want %b", cyc, imem_req_valid, exp_req);
    end
    if (exp_req) begin
      n_cmp++;
      if (imem_req_addr !== exp_fetch) begin
        n_fail++;
        $display("FAIL req_addr cyc=%0d: got %h want %h", cyc, imem_req_addr, exp_fetch);
      end
    end
    n_cmp++;
    if (occupancy !== 3'(bufq.size())) begin
      n_fail++;
      $display("FAIL occupancy cyc=%0d: got %0d want %0d", cyc, occupancy, bufq.size());
    end
    n_cmp++;
    if (dec_valid !== (bufq.size() != 0)) begin
      n_fail++;
      $display("FAIL dec_valid cyc=%0d: got %b want %b", cyc, dec_valid, bufq.size() != 0);
    end
    if (bufq.size() != 0) begin
      n_cmp++;
      if (dec_pc !== bufq[0] || dec_pc_plus4 !== bufq[0] + 32'd4 ||
          dec_instr !== memfn(bufq[0])) begin
        n_fail++;
        $display("FAIL dec_head cyc=%0d: got pc=%h pc4=%h instr=%h want pc=%h pc4=%h instr=%h",
                 cyc, dec_pc, dec_pc_plus4, dec_instr, bufq[0], bufq[0] + 32'd4, memfn(bufq[0]));
      end
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    n_cmp++;
    if (fetch_misaligned !== mis_m) begin
      n_fail++;
      $display("FAIL misaligned_flag cyc=%0d: got %b want %b", cyc, fetch_misaligned, mis_m);
    end
`endif
    if (dec_valid && dec_ready && !redirect_valid) popped.push_back(dec_pc);
    if (bufq.size() != 0 && dec_ready && !redirect_valid) void'(bufq.pop_front());
    if (imem_rsp_valid && infl.size() != 0) begin
      e = infl.pop_front();
      if (e.live && !redirect_valid) bufq.push_back(e.addr);
    end
    if (imem_req_valid && imem_req_ready) begin
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      infl.push_back('{addr: imem_req_addr, due: d, live: 1'b1});
      reqs.push_back(imem_req_addr);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (redirect_valid) begin
      foreach (infl[i]) infl[i].live = 1'b0;
      bufq.delete();
      exp_fetch = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_m = (redirect_pc[1:0] != 2'b00);
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
    drive_imem();
  endtask

  task automatic wait_pops(input int n, input string name);
    int k;
    k = 0;
    while (popped.size() < n && k < 40) begin
      tick();
      k++;
    end
    n_cmp++;
    if (popped.size() < n) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d pops want %0d", name, popped.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (dec_valid !== 1'b0 || occupancy !== 3'd0 || imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got dv=%b occ=%0d rv=%b want 0 0 0",
               dec_valid, occupancy, imem_req_valid);
    end
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_req: got v=%b a=%h want 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    drive_imem();
  endtask

  task automatic test_stream();
    lat_min = 1; lat_max = 1; rdy_pct = 100; dec_ready = 1'b1;
    drive_imem();
    repeat (12) tick();
    n_cmp++;
    if (reqs.size() < 3 || reqs[0] !== 32'h0 || reqs[1] !== 32'h4 || reqs[2] !== 32'h8) begin
      n_fail++;
      $display("FAIL stream_reqs: got %p want 0,4,8...", reqs);
    end
    n_cmp++;
    if (popped.size() != 10 || popped[0] !== 32'h0 || popped[1] !== 32'h4 || popped[2] !== 32'h8) begin
      n_fail++;
      $display("FAIL stream_pops: got %0d pops %p want 10 starting 0,4,8", popped.size(), popped);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] nxt;
    nxt = popped[popped.size() - 1] + 32'd4;
    dec_ready = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if (occupancy !== 3'(DEPTH) || imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: got occ=%0d rv=%b want %0d 0", occupancy, imem_req_valid, DEPTH);
    end
    popped.delete();
    dec_ready = 1'b1;
    repeat (8) tick();
    n_cmp++;
    if (popped.size() < 6) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d pops want >=6", popped.size());
    end
    foreach (popped[i]) begin
      n_cmp++;
      if (popped[i] !== nxt + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL bp_order[%0d]: got %h want %h", i, popped[i], nxt + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_stale();
    int k;
    lat_min = 3; lat_max = 3; dec_ready = 1'b1;
    k = 0;
    while (infl.size() != 2 && k < 20) begin
      tick();
      k++;
    end
    n_cmp++;
    if (infl.size() != 2) begin
      n_fail++;
      $display("FAIL stale_setup: got %0d in flight want 2", infl.size());
    end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    popped.delete();
    wait_pops(2, "stale");
    n_cmp++;
    if (popped.size() < 2 || popped[0] !== 32'h100 || popped[1] !== 32'h104) begin
      n_fail++;
      $display("FAIL stale_target: got %p want 100,104", popped);
    end
  endtask

  task automatic test_redirect_collision();
    int k;
    lat_min = 1; lat_max = 1; dec_ready = 1'b1;
    k = 0;
    while (!(imem_rsp_valid && dec_valid) && k < 20) begin
      tick();
      k++;
    end
    n_cmp++;
    if (!(imem_rsp_valid && dec_valid)) begin
      n_fail++;
      $display("FAIL coll_setup: got rsp=%b dv=%b want 1 1", imem_rsp_valid, dec_valid);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    popped.delete();
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (occupancy !== 3'd0 || dec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_flush: got occ=%0d dv=%b want 0 0", occupancy, dec_valid);
    end
    wait_pops(1, "coll");
    n_cmp++;
    if (popped.size() < 1 || popped[0] !== 32'h300) begin
      n_fail++;
      $display("FAIL coll_target: got %p want 300", popped);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    lat_min = 1; lat_max = 1; dec_ready = 1'b0;
    k = 0;
    while (occupancy !== 3'd3 && k < 20) begin
      tick();
      k++;
    end
    n_cmp++;
    if (occupancy !== 3'd3) begin
      n_fail++;
      $display("FAIL rstmid_setup: got occ=%0d want 3", occupancy);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (dec_valid !== 1'b0 || occupancy !== 3'd0 || imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_clear: got dv=%b occ=%0d rv=%b want 0 0 0",
               dec_valid, occupancy, imem_req_valid);
    end
    model_reset();
    imem_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL rstmid_req: got v=%b a=%h want 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    drive_imem();
    dec_ready = 1'b1;
    wait_pops(1, "rstmid");
    n_cmp++;
    if (popped.size() < 1 || popped[0] !== RESET_PC) begin
      n_fail++;
      $display("FAIL rstmid_pop: got %p want %h", popped, RESET_PC);
    end
  endtask

`ifdef FETCH_MISALIGN_TRAP_EN
  task automatic test_misalign();
    dec_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (fetch_misaligned !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_set: got %b want 1", fetch_misaligned);
    end
    repeat (5) begin
      n_cmp++;
      if (imem_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mis_block: got rv=%b want 0", imem_req_valid);
      end
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    popped.delete();
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (fetch_misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_clear: got %b want 0", fetch_misaligned);
    end
    wait_pops(1, "mis");
    n_cmp++;
    if (popped.size() < 1 || popped[0] !== 32'h200) begin
      n_fail++;
      $display("FAIL mis_target: got %p want 200", popped);
    end
  endtask
`endif

  task automatic test_random();
    lat_min = 1; lat_max = 4; rdy_pct = 70;
    repeat (600) begin
      dec_ready      = ($urandom_range(3, 0) != 0);
      redirect_valid = ($urandom_range(24, 0) == 0);
      redirect_pc    = $urandom;
      if ($urandom_range(3, 0) != 0) redirect_pc[1:0] = 2'b00;
      if ($urandom_range(4, 0) == 0) redirect_pc[31:4] = 28'hFFF_FFFF;
      tick();
    end
    redirect_valid = 1'b0;
    rdy_pct = 100;
    drive_imem();
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    reset = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_collision();
    test_reset_mid();
`ifdef FETCH_MISALIGN_TRAP_EN
    test_misalign();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
